// File: rtl/field_arith_defs.sv
// Shared prime-field definitions: width `F_NBITS, modulus q = 2^61-1 and the
// offset constant used for single-compare modular reduction.
`ifndef F_NBITS
`define F_NBITS 61
`endif

package field_arith_defs;

    localparam int F_NBITS = `F_NBITS;

    // Mersenne prime 2^F_NBITS - 1
    localparam logic [F_NBITS-1:0] FIELD_Q = '1;

    // 2^F_NBITS - q: a+b >= q exactly when a+b+offset carries out of F_NBITS bits
    localparam logic [F_NBITS:0] FIELD_OFFSET = {1'b1, {F_NBITS{1'b0}}} - {1'b0, FIELD_Q};

    function automatic logic [F_NBITS-1:0] add_mod(input logic [F_NBITS-1:0] a,
                                                   input logic [F_NBITS-1:0] b);
        logic [F_NBITS+1:0] t;
        t = {2'b00, a} + {2'b00, b} + {1'b0, FIELD_OFFSET};
        return (t[F_NBITS+1:F_NBITS] != 2'b00) ? t[F_NBITS-1:0] : (a + b);
    endfunction

endpackage

// File: rtl/field_adder.sv
// Registered modular adder: one-cycle en pulse, result valid when ready returns high.
module field_adder
    import field_arith_defs::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [`F_NBITS-1:0] a,
    input  logic [`F_NBITS-1:0] b,
    output logic [`F_NBITS-1:0] sum,
    output logic               ready
);

    logic busy;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            busy <= 1'b0;
        end else begin
            busy <= en;
            if (en) sum <= add_mod(a, b);
        end
    end

    assign ready = ~busy;

endmodule

// File: rtl/field_multiplier.sv
// Iterative modular multiplier: MSB-first double-and-add, one operand bit per cycle.
module field_multiplier
    import field_arith_defs::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [`F_NBITS-1:0] a,
    input  logic [`F_NBITS-1:0] b,
    output logic [`F_NBITS-1:0] p,
    output logic               ready
);

    localparam int CW = $clog2(F_NBITS);

    logic [F_NBITS-1:0] a_q;
    logic [F_NBITS-1:0] b_q;
    logic [F_NBITS-1:0] acc;
    logic [F_NBITS-1:0] dbl;
    logic [CW-1:0]      cnt;
    logic               busy;

    assign dbl = add_mod(acc, acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (en) begin
            a_q  <= a;
            b_q  <= b;
            acc  <= '0;
            cnt  <= CW'(F_NBITS - 1);
            busy <= 1'b1;
        end else if (busy) begin
            acc <= b_q[F_NBITS-1] ? add_mod(dbl, a_q) : dbl;
            b_q <= b_q << 1;
            if (cnt == '0) busy <= 1'b0;
            else           cnt  <= cnt - 1'b1;
        end
    end

    assign p     = acc;
    assign ready = ~busy;

endmodule

// File: rtl/sumcheck_round_eval.sv
// Sumcheck round evaluator: f(r) by Horner over the shared field units.
// Define SUMCHECK_CHECK_EN to add the f(0)+f(1) == claim check; otherwise check_ok is 1.
module sumcheck_round_eval
    import field_arith_defs::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     cubic,
    input  logic [3:0][`F_NBITS-1:0] c_in,
    input  logic [`F_NBITS-1:0]      r_in,
    input  logic [`F_NBITS-1:0]      claim_in,
    output logic [`F_NBITS-1:0]      eval_out,
    output logic                     check_ok,
    output logic                     ready,
    output logic                     ready_pulse
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MUL  = 3'd1;
    localparam logic [2:0] ST_ADD  = 3'd2;
`ifdef SUMCHECK_CHECK_EN
    localparam logic [2:0] ST_CHK0 = 3'd3;
    localparam logic [2:0] ST_CHK1 = 3'd4;
    localparam logic [2:0] ST_CHK2 = 3'd5;
`endif

    logic [2:0]                 state;
    logic                       en_dly;
    logic                       ready_dly;
    logic                       start;
    logic [3:0][F_NBITS-1:0]    c_q;
    logic [F_NBITS-1:0]         r_q;
    logic                       cubic_q;
    logic [F_NBITS-1:0]         acc;
    logic [1:0]                 idx;

    logic                       mul_en;
    logic                       mul_ready;
    logic [F_NBITS-1:0]         mul_p;
    logic                       add0_en;
    logic                       add0_ready;
    logic [F_NBITS-1:0]         add0_sum;
    logic [F_NBITS-1:0]         add0_a;
    logic [F_NBITS-1:0]         add0_b;

    assign start       = en & ~en_dly;
    assign ready       = (state == ST_IDLE) & ~start;
    assign ready_pulse = ready & ~ready_dly;

    field_multiplier u_mul (
        .clk   (clk),
        .rst   (rst),
        .en    (mul_en),
        .a     (acc),
        .b     (r_q),
        .p     (mul_p),
        .ready (mul_ready)
    );

    field_adder u_add0 (
        .clk   (clk),
        .rst   (rst),
        .en    (add0_en),
        .a     (add0_a),
        .b     (add0_b),
        .sum   (add0_sum),
        .ready (add0_ready)
    );

`ifdef SUMCHECK_CHECK_EN
    logic                 add1_en;
    logic                 add1_ready;
    logic [F_NBITS-1:0]   add1_sum;
    logic [F_NBITS-1:0]   claim_q;

    field_adder u_add1 (
        .clk   (clk),
        .rst   (rst),
        .en    (add1_en),
        .a     (c_q[1]),
        .b     (c_q[2]),
        .sum   (add1_sum),
        .ready (add1_ready)
    );
`else
    logic unused_claim;
    assign unused_claim = ^claim_in;
    assign check_ok     = 1'b1;
`endif

    // NOTE: outputs of always_comb get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        add0_a = mul_p;
        add0_b = c_q[idx];
`ifdef SUMCHECK_CHECK_EN
        case (state)
            ST_CHK0: begin add0_a = c_q[0];   add0_b = c_q[0];   end
            ST_CHK1: begin add0_a = add0_sum; add0_b = add1_sum; end
            ST_CHK2: begin add0_a = add0_sum; add0_b = cubic_q ? c_q[3] : '0; end
            default: ;
        endcase
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            en_dly    <= 1'b1;
            ready_dly <= 1'b1;
            c_q       <= '0;
            r_q       <= '0;
            cubic_q   <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            mul_en    <= 1'b0;
            add0_en   <= 1'b0;
            eval_out  <= '0;
`ifdef SUMCHECK_CHECK_EN
            add1_en   <= 1'b0;
            claim_q   <= '0;
            check_ok  <= 1'b0;
`endif
        end else begin
            en_dly    <= en;
            ready_dly <= ready;
            mul_en    <= 1'b0;
            add0_en   <= 1'b0;
`ifdef SUMCHECK_CHECK_EN
            add1_en   <= 1'b0;
`endif
            case (state)
                ST_IDLE: if (start) begin
                    c_q     <= c_in;
                    r_q     <= r_in;
                    cubic_q <= cubic;
`ifdef SUMCHECK_CHECK_EN
                    claim_q <= claim_in;
`endif
                    acc     <= cubic ? c_in[3] : c_in[2];
                    idx     <= cubic ? 2'd2 : 2'd1;
                    mul_en  <= 1'b1;
                    state   <= ST_MUL;
                end
                ST_MUL: if (mul_ready && !mul_en) begin
                    add0_en <= 1'b1;
                    state   <= ST_ADD;
                end
                // idx names the coefficient being added; reaching c0 ends the Horner chain
                ST_ADD: if (add0_ready && !add0_en) begin
                    acc <= add0_sum;
                    if (idx == 2'd0) begin
`ifdef SUMCHECK_CHECK_EN
                        add0_en <= 1'b1;
                        add1_en <= 1'b1;
                        state   <= ST_CHK0;
`else
                        eval_out <= add0_sum;
                        state    <= ST_IDLE;
`endif
                    end else begin
                        idx    <= idx - 2'd1;
                        mul_en <= 1'b1;
                        state  <= ST_MUL;
                    end
                end
`ifdef SUMCHECK_CHECK_EN
                ST_CHK0: if (add0_ready && add1_ready && !add0_en) begin
                    add0_en <= 1'b1;
                    state   <= ST_CHK1;
                end
                ST_CHK1: if (add0_ready && !add0_en) begin
                    add0_en <= 1'b1;
                    state   <= ST_CHK2;
                end
                ST_CHK2: if (add0_ready && !add0_en) begin
                    eval_out <= acc;
                    check_ok <= (add0_sum == claim_q);
                    state    <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sumcheck_round_eval.sv
// Scoreboard bench for sumcheck_round_eval; expectations come from a direct power-sum model.
module tb_sumcheck_round_eval;

    localparam int W = field_arith_defs::F_NBITS;
    localparam logic [127:0] FQ = 128'(field_arith_defs::FIELD_Q);
    localparam int TIMEOUT = 1000;

`ifdef SUMCHECK_CHECK_EN
    localparam logic RST_OK = 1'b0;
`else
    localparam logic RST_OK = 1'b1;
`endif

    typedef struct packed {
        logic [W-1:0] eval;
        logic         ok;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en = 1'b0;
    logic                cubic = 1'b0;
    logic [3:0][W-1:0]   c_in = '0;
    logic [W-1:0]        r_in = '0;
    logic [W-1:0]        claim_in = '0;
    logic [W-1:0]        eval_out;
    logic                check_ok;
    logic                ready;
    logic                ready_pulse;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt = 0;

    sumcheck_round_eval dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cubic       (cubic),
        .c_in        (c_in),
        .r_in        (r_in),
        .claim_in    (claim_in),
        .eval_out    (eval_out),
        .check_ok    (check_ok),
        .ready       (ready),
        .ready_pulse (ready_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ready_pulse === 1'b1) pulse_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_fe();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return W'(128'(t) % FQ);
    endfunction

    function automatic logic [3:0][W-1:0] mk(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                             input logic [W-1:0] a2, input logic [W-1:0] a3);
        logic [3:0][W-1:0] c;
        c[0] = a0; c[1] = a1; c[2] = a2; c[3] = a3;
        return c;
    endfunction

    function automatic logic [W-1:0] chk_sum(input logic cub, input logic [3:0][W-1:0] c);
        logic [127:0] s;
        s = 128'(c[0]) * 2 + 128'(c[1]) + 128'(c[2]) + (cub ? 128'(c[3]) : 128'd0);
        return W'(s % FQ);
    endfunction

    function automatic exp_t model(input logic cub, input logic [3:0][W-1:0] c,
                                   input logic [W-1:0] r, input logic [W-1:0] claim);
        logic [127:0] r1, r2, r3, f;
        exp_t e;
        r1 = 128'(r);
        r2 = (r1 * r1) % FQ;
        r3 = (r2 * r1) % FQ;
        f  = 128'(c[0]) + (128'(c[1]) * r1) % FQ + (128'(c[2]) * r2) % FQ
           + (cub ? (128'(c[3]) * r3) % FQ : 128'd0);
        e.eval = W'(f % FQ);
`ifdef SUMCHECK_CHECK_EN
        e.ok = (chk_sum(cub, c) == claim);
`else
        e.ok = 1'b1;
`endif
        return e;
    endfunction

    task automatic run_eval(input string tag, input logic cub, input logic [3:0][W-1:0] c,
                            input logic [W-1:0] r, input logic [W-1:0] claim,
                            input bit hold_en, input bit scramble);
        exp_t e;
        int   n;
        int   p0;
        sb.push_back(model(cub, c, r, claim));
        @(negedge clk);
        cubic = cub; c_in = c; r_in = r; claim_in = claim; en = 1'b1;
        p0 = pulse_cnt;
        @(negedge clk);
        check({tag, "_busy"}, 64'(ready), 64'd0);
        if (!hold_en) en = 1'b0;
        if (scramble) begin
            c_in = mk(rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe());
            r_in = rnd_fe(); claim_in = rnd_fe(); cubic = ~cub;
        end
        n = 0;
        while (ready_pulse !== 1'b1 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 64'(n < TIMEOUT), 64'd1);
        e = sb.pop_front();
        check({tag, "_eval"}, 64'(eval_out), 64'(e.eval));
        check({tag, "_ok"}, 64'(check_ok), 64'(e.ok));
        if (hold_en) begin
            repeat (400) @(negedge clk);
            check({tag, "_hold_eval"}, 64'(eval_out), 64'(e.eval));
            en = 1'b0;
        end
        repeat (4) @(negedge clk);
        check({tag, "_pulses"}, 64'(pulse_cnt - p0), 64'd1);
    endtask

    initial begin
        logic [3:0][W-1:0] qm1;
        logic [3:0][W-1:0] rc;
        logic              rcub;
        logic [W-1:0]      qv;
        qv  = W'(FQ);
        qm1 = mk(qv - 1, qv - 1, qv - 1, qv - 1);

        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_eval", 64'(eval_out), 64'd0);
        check("rst_ok", 64'(check_ok), 64'(RST_OK));
        check("rst_pulse", 64'(ready_pulse), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_eval("cubic_49", 1'b1, mk(1, 2, 3, 4), 2, 11, 1'b0, 1'b0);
        run_eval("quad_11", 1'b0, mk(5, 0, 1, 'h1dead), 3, 11, 1'b0, 1'b0);
        run_eval("quad_12", 1'b0, mk(5, 0, 1, 'h1dead), 3, 12, 1'b0, 1'b0);
        run_eval("qm1_r1", 1'b1, qm1, 1, 0, 1'b0, 1'b0);
        run_eval("qm1_r0", 1'b1, qm1, 0, chk_sum(1'b1, qm1), 1'b0, 1'b0);
        run_eval("hold_en", 1'b1, mk(7, 8, 9, 10), 5, 41, 1'b1, 1'b0);
        run_eval("scramble", 1'b1, mk(1, 2, 3, 4), 2, 11, 1'b0, 1'b1);

        // abandon an evaluation while the multiplier is busy
        @(negedge clk);
        cubic = 1'b1; c_in = mk(9, 9, 9, 9); r_in = 9; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_eval", 64'(eval_out), 64'd0);
        check("abort_ok", 64'(check_ok), 64'(RST_OK));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_eval("after_abort", 1'b0, mk(5, 0, 1, 0), 3, 11, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            rc   = mk(rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe());
            rcub = 1'($urandom_range(0, 1));
            run_eval($sformatf("rand%0d", i), rcub, rc, rnd_fe(),
                     (i % 2 == 0) ? chk_sum(rcub, rc) : rnd_fe(), 1'b0, 1'b0);
        end

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
